// File: rtl/miner_pkg.sv
// Shared definitions for the nonce sweeper and its helpers.
//   HEADER_W / HASH_W / NONCE_W : widths of header, hash and nonce fields
//   state_t                     : sweeper FSM state encoding
//   bswap32 / bswap256          : byte-order reversal helpers
package miner_pkg;

   localparam int HEADER_W = 640;
   localparam int HASH_W   = 256;
   localparam int NONCE_W  = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KICK   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Reverse the four bytes of a nonce (the header stores it little-endian).
   function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Reverse the 32 bytes of a hash: byte 0 (MSB) becomes the least significant byte.
   function automatic logic [HASH_W-1:0] bswap256(input logic [HASH_W-1:0] v);
      logic [HASH_W-1:0] r;
      r = '0;
      for (int i = 0; i < HASH_W / 8; i++) begin
         r[8*i +: 8] = v[HASH_W-8-8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Combinational difficulty check.
//   hash   : digest in miner byte order (first byte in the MSBs)
//   target : unsigned 256-bit difficulty target
//   hit    : 1 when the digest read as a little-endian integer is <= target
module hash_target_cmp
   import miner_pkg::*;
(
   input  logic [HASH_W-1:0] hash,
   input  logic [HASH_W-1:0] target,
   output logic              hit
);

   logic [HASH_W-1:0] hash_le;

   assign hash_le = bswap256(hash);
   assign hit     = (hash_le <= target);

endmodule

// File: rtl/nonce_sweeper.sv
// Sweeps an inclusive nonce range through an external miner core, stopping at
// the first nonce whose hash meets the target, at the end of the range, or when
// a single miner run exceeds TIMEOUT_CYCLES wait cycles.
//   clk, rst (async, active low)
//   start, abort            : sweep control (start honoured only when idle)
//   header, nonce_first, nonce_last, target : sweep job, latched on accepted start
//   miner_block, miner_rst  : drive the miner core
//   miner_hashed, miner_done: miner result
//   busy, done              : status; done pulses once at the end of a sweep
//   found, exhausted, timeout, nonce_out, hash_out : result, held until next start
//   state_dbg               : current FSM state for observation
//
// Handshake: start is a single-cycle request, accepted only in IDLE with abort
// low; miner_done is a level that is trusted only from the second WAIT cycle
// onward, so a stale done from the previous run cannot be mistaken for a result.
module nonce_sweeper
   import miner_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [HEADER_W-1:0] header,
   input  logic [NONCE_W-1:0]  nonce_first,
   input  logic [NONCE_W-1:0]  nonce_last,
   input  logic [HASH_W-1:0]   target,
   output logic [HEADER_W-1:0] miner_block,
   output logic                miner_rst,
   input  logic [HASH_W-1:0]   miner_hashed,
   input  logic                miner_done,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic                exhausted,
   output logic                timeout,
   output logic [NONCE_W-1:0]  nonce_out,
   output logic [HASH_W-1:0]   hash_out,
   output logic [2:0]          state_dbg
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic [HEADER_W-1:0]  hdr_q;
   logic [HASH_W-1:0]    tgt_q;
   logic [HASH_W-1:0]    hash_q;
   logic [NONCE_W-1:0]   cur_q;
   logic [NONCE_W-1:0]   last_q;
   logic [CNT_W-1:0]     wait_cnt;
   logic                 hit;
   logic                 accept;
   logic                 cancel;
   logic                 done_ok;
   logic                 expire;
   logic                 at_last;
   logic                 unused_hdr_bits;

   // The nonce field of the template is always replaced by the current nonce.
   assign unused_hdr_bits = ^hdr_q[NONCE_W-1:0];

   assign miner_block = {hdr_q[HEADER_W-1:NONCE_W], bswap32(cur_q)};
   assign state_dbg   = state_q;

   assign accept  = (state_q == ST_IDLE) && start && !abort;
   assign cancel  = (state_q != ST_IDLE) && abort;
   // First WAIT cycle (wait_cnt == 0) never qualifies miner_done.
   assign done_ok = (state_q == ST_WAIT) && (wait_cnt != '0) && miner_done;
   assign expire  = (state_q == ST_WAIT) && !done_ok && (wait_cnt == CNT_LAST);
   assign at_last = (cur_q == last_q);

   hash_target_cmp u_cmp (
      .hash   (hash_q),
      .target (tgt_q),
      .hit    (hit)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_KICK;
         ST_KICK:   state_d = ST_WAIT;
         ST_WAIT: begin
            if (done_ok)     state_d = ST_CHECK;
            else if (expire) state_d = ST_FINISH;
         end
         ST_CHECK:  state_d = (hit || at_last) ? ST_FINISH : ST_KICK;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (cancel) state_d = ST_IDLE;
   end

   // Output logic
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      miner_rst = 1'b1;
      case (state_q)
         ST_KICK:   busy = 1'b1;
         ST_WAIT: begin
            busy      = 1'b1;
            miner_rst = 1'b0;
         end
         ST_CHECK: begin
            busy      = 1'b1;
            miner_rst = 1'b0;
         end
         ST_FINISH: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Job registers, wait counter and result flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_q     <= '0;
         tgt_q     <= '0;
         hash_q    <= '0;
         cur_q     <= '0;
         last_q    <= '0;
         wait_cnt  <= '0;
         found     <= 1'b0;
         exhausted <= 1'b0;
         timeout   <= 1'b0;
         nonce_out <= '0;
         hash_out  <= '0;
      end else if (cancel) begin
         found     <= 1'b0;
         exhausted <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  hdr_q     <= header;
                  tgt_q     <= target;
                  last_q    <= nonce_last;
                  cur_q     <= nonce_first;
                  found     <= 1'b0;
                  exhausted <= 1'b0;
                  timeout   <= 1'b0;
               end
            end
            ST_KICK: wait_cnt <= '0;
            ST_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (done_ok) begin
                  hash_q <= miner_hashed;
               end else if (expire) begin
                  timeout   <= 1'b1;
                  nonce_out <= cur_q;
               end
            end
            ST_CHECK: begin
               if (hit) begin
                  found     <= 1'b1;
                  nonce_out <= cur_q;
                  hash_out  <= hash_q;
               end else if (at_last) begin
                  exhausted <= 1'b1;
                  nonce_out <= cur_q;
               end else begin
                  // Wraps through 0xFFFFFFFF to 0 when the range crosses zero.
                  cur_q <= cur_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_sweeper.sv
// Bench for nonce_sweeper: a behavioural double-SHA-256 miner responds to the
// DUT, and a reference model of the sweep rules predicts kicks and results.
module tb_nonce_sweeper;

   localparam int TMO = 16;

   logic         clk;
   logic         rst;
   logic         start;
   logic         abort;
   logic [639:0] header;
   logic [31:0]  nonce_first;
   logic [31:0]  nonce_last;
   logic [255:0] target;
   logic [639:0] miner_block;
   logic         miner_rst;
   logic [255:0] miner_hashed;
   logic         miner_done;
   logic         busy;
   logic         done;
   logic         found;
   logic         exhausted;
   logic         timeout;
   logic [31:0]  nonce_out;
   logic [255:0] hash_out;
   logic [2:0]   state_dbg;

   nonce_sweeper #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .header       (header),
      .nonce_first  (nonce_first),
      .nonce_last   (nonce_last),
      .target       (target),
      .miner_block  (miner_block),
      .miner_rst    (miner_rst),
      .miner_hashed (miner_hashed),
      .miner_done   (miner_done),
      .busy         (busy),
      .done         (done),
      .found        (found),
      .exhausted    (exhausted),
      .timeout      (timeout),
      .nonce_out    (nonce_out),
      .hash_out     (hash_out),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- SHA-256 reference ----------------
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] m);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
              + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
              e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
   endfunction

   function automatic logic [255:0] sha256d(input logic [639:0] blk);
      logic [255:0] h1;
      h1 = sha_blk(H0, blk[639:128]);
      h1 = sha_blk(h1, {blk[127:0], 8'h80, 312'b0, 64'd640});
      return sha_blk(H0, {h1, 8'h80, 184'b0, 64'd256});
   endfunction

   function automatic logic [31:0] le32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [255:0] rev256(input logic [255:0] v);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[255-8*i -: 8] = v[8*i +: 8];
      return r;
   endfunction

   // ---------------- behavioural miner ----------------
   logic miner_stall;
   int   m_cnt;
   int   m_lat;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         miner_done   <= 1'b0;
         miner_hashed <= '0;
         m_cnt        <= 0;
         m_lat        <= 1;
      end else if (miner_rst) begin
         miner_done <= 1'b0;
         m_cnt      <= 0;
         m_lat      <= $urandom_range(1, 10);
      end else begin
         m_cnt <= m_cnt + 1;
         if (!miner_stall && (m_cnt + 1 == m_lat)) begin
            miner_done   <= 1'b1;
            miner_hashed <= sha256d(miner_block);
         end
      end
   end

   // ---------------- scoreboard ----------------
   int           n_assert = 0;
   int           n_fail = 0;
   logic [31:0]  exp_q [$];
   logic [31:0]  seen_q [$];
   logic [639:0] hdr_exp;
   int           kick_cnt;
   int           wait_cyc;

   task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each KICK cycle shows one new nonce to the miner; compare it to the model.
   always @(negedge clk) begin
      if (rst && busy) begin
         if (miner_rst && !done) begin
            kick_cnt++;
            wait_cyc = 0;
            seen_q.push_back(miner_block[31:0]);
            n_assert++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL extra_kick: observed nonce field %0h expected no kick", miner_block[31:0]);
            end
            if (exp_q.size() != 0) begin
               check("kick_nonce", miner_block[31:0], exp_q.pop_front());
               check("kick_header", miner_block[639:32], hdr_exp[639:32]);
            end
         end else if (!miner_rst) begin
            wait_cyc++;
         end
      end
   end

   // Reference: walk the range with plain arithmetic, apply the stop rules.
   task automatic model_sweep(input logic [639:0] hdr, input logic [31:0] first, input logic [31:0] last,
                              input logic [255:0] tgt, input bit stall,
                              output bit e_found, output bit e_exh, output bit e_tmo,
                              output logic [31:0] e_nonce, output logic [255:0] e_hash, output int e_kicks);
      logic [31:0]  n;
      logic [255:0] h;
      n = first;
      e_found = 0; e_exh = 0; e_tmo = 0; e_nonce = '0; e_hash = '0; e_kicks = 0;
      if (stall) begin
         exp_q.push_back(le32(first));
         e_tmo = 1; e_nonce = first; e_kicks = 1;
         return;
      end
      for (int i = 0; i < 1000; i++) begin
         e_kicks++;
         exp_q.push_back(le32(n));
         h = sha256d({hdr[639:32], le32(n)});
         if (rev256(h) <= tgt) begin
            e_found = 1; e_nonce = n; e_hash = h;
            break;
         end
         if (n == last) begin
            e_exh = 1; e_nonce = n;
            break;
         end
         n = n + 32'd1;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic start_only(input logic [639:0] hdr, input logic [31:0] first, input logic [31:0] last,
                             input logic [255:0] tgt);
      hdr_exp = hdr;
      kick_cnt = 0;
      seen_q.delete();
      @(negedge clk);
      header = hdr; nonce_first = first; nonce_last = last; target = tgt; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_for_wait(input string tag);
      bit got;
      got = 0;
      for (int c = 0; c < 50; c++) begin
         if (busy && !miner_rst) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      n_assert++;
      assert (got) else begin
         n_fail++;
         $error("FAIL %s_reach_wait: observed no WAIT within 50 cycles expected WAIT", tag);
      end
   endtask

   task automatic run_sweep(input string tag, input logic [639:0] hdr, input logic [31:0] first,
                            input logic [31:0] last, input logic [255:0] tgt, input bit stall, input bit glitch);
      bit           e_found, e_exh, e_tmo, got;
      logic [31:0]  e_nonce;
      logic [255:0] e_hash;
      int           e_kicks;
      exp_q.delete();
      model_sweep(hdr, first, last, tgt, stall, e_found, e_exh, e_tmo, e_nonce, e_hash, e_kicks);
      miner_stall = stall;
      start_only(hdr, first, last, tgt);
      check({tag, "_busy"}, busy, 1'b1);
      if (glitch) begin
         // A second start while busy must not re-latch anything.
         start = 1'b1;
         header = {20{$urandom}};
         nonce_first = ~first;
         target = '1;
         @(negedge clk);
         start = 1'b0;
      end
      got = 0;
      for (int c = 0; c < 1500; c++) begin
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      n_assert++;
      assert (got) else begin
         n_fail++;
         $error("FAIL %s_done: observed no done within 1500 cycles expected done pulse", tag);
      end
      if (got) begin
         check({tag, "_found"}, found, e_found);
         check({tag, "_exhausted"}, exhausted, e_exh);
         check({tag, "_timeout"}, timeout, e_tmo);
         check({tag, "_one_flag"}, 32'(found) + 32'(exhausted) + 32'(timeout), 1);
         check({tag, "_kicks"}, kick_cnt, e_kicks);
         check({tag, "_exp_left"}, exp_q.size(), 0);
         if (!e_tmo) check({tag, "_nonce_out"}, nonce_out, e_nonce);
         if (e_found) check({tag, "_hash_out"}, hash_out, e_hash);
         if (e_tmo) check({tag, "_wait_cycles"}, wait_cyc, TMO);
         @(negedge clk);
         check({tag, "_done_pulse"}, done, 1'b0);
         check({tag, "_idle"}, busy, 1'b0);
         check({tag, "_found_hold"}, found, e_found);
         if (!e_tmo) check({tag, "_nonce_hold"}, nonce_out, e_nonce);
      end
      miner_stall = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_found"}, found, 1'b0);
      check({tag, "_exhausted"}, exhausted, 1'b0);
      check({tag, "_timeout"}, timeout, 1'b0);
      check({tag, "_nonce_out"}, nonce_out, 32'h0);
      check({tag, "_hash_out"}, hash_out, 256'h0);
      check({tag, "_miner_rst"}, miner_rst, 1'b1);
      check({tag, "_miner_block"}, miner_block, 640'h0);
   endtask

   // ---------------- directed sequence ----------------
   localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
      256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
      32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
   localparam logic [255:0] GEN_TGT  = {48'h00000000ffff, 208'h0};
   localparam logic [255:0] GEN_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

   initial begin
      logic [639:0] hdr;
      logic [31:0]  first, len, dones;
      logic [255:0] tgt;

      rst = 1'b0; start = 1'b0; abort = 1'b0; header = '0;
      nonce_first = '0; nonce_last = '0; target = '0; miner_stall = 1'b0;
      hdr_exp = '0; kick_cnt = 0; wait_cyc = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_busy", busy, 1'b0);

      // abort overrides start in IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("idle_abort_busy", busy, 1'b0);
      check("idle_abort_miner_rst", miner_rst, 1'b1);

      // genesis block, single nonce
      run_sweep("genesis", GEN_HDR, 32'h7C2BAC1D, 32'h7C2BAC1D, GEN_TGT, 0, 0);
      check("genesis_found_k", found, 1'b1);
      check("genesis_nonce_k", nonce_out, 32'h7C2BAC1D);
      check("genesis_hash_k", rev256(hash_out), rev256(GEN_HASH));
      check("genesis_kicks_k", kick_cnt, 1);

      // genesis block, three nonces ending on the winner
      run_sweep("genesis3", GEN_HDR, 32'h7C2BAC1B, 32'h7C2BAC1D, GEN_TGT, 0, 1);
      check("genesis3_kicks_k", kick_cnt, 3);
      check("genesis3_found_k", found, 1'b1);
      check("genesis3_nonce_k", nonce_out, 32'h7C2BAC1D);

      // reset in the middle of WAIT
      exp_q.delete();
      exp_q.push_back(le32(32'h00000050));
      miner_stall = 1'b1;
      start_only(GEN_HDR, 32'h00000050, 32'h00000060, 256'h0);
      wait_for_wait("rst_mid");
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("rst_mid");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_resume_idle", busy, 1'b0);
      miner_stall = 1'b0;
      exp_q.delete();

      // impossible target, range 0..2
      hdr = {20{$urandom}};
      run_sweep("exhaust", hdr, 32'h0, 32'h2, 256'h0, 0, 0);
      check("exhaust_kicks_k", kick_cnt, 3);
      check("exhaust_flag_k", exhausted, 1'b1);
      check("exhaust_found_k", found, 1'b0);
      check("exhaust_nonce_k", nonce_out, 32'h2);

      // range wrapping through zero
      run_sweep("wrap", hdr, 32'hFFFFFFFF, 32'h00000001, 256'h0, 0, 0);
      check("wrap_seen_n", seen_q.size(), 3);
      if (seen_q.size() == 3) begin
         check("wrap_seen0", seen_q[0], 32'hFFFFFFFF);
         check("wrap_seen1", seen_q[1], 32'h00000000);
         check("wrap_seen2", seen_q[2], 32'h01000000);
      end
      check("wrap_exhausted_k", exhausted, 1'b1);
      check("wrap_nonce_k", nonce_out, 32'h1);

      // miner never finishes
      run_sweep("tmo", hdr, 32'h5, 32'h9, 256'h0, 1, 0);
      check("tmo_flag_k", timeout, 1'b1);

      // abort during WAIT
      exp_q.delete();
      exp_q.push_back(le32(32'h00001234));
      miner_stall = 1'b1;
      start_only(hdr, 32'h00001234, 32'h00001240, 256'h0);
      wait_for_wait("abort");
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_miner_rst", miner_rst, 1'b1);
      check("abort_done", done, 1'b0);
      check("abort_flags", {found, exhausted, timeout}, 3'b000);
      @(negedge clk);
      abort = 1'b0;
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_exp_left", exp_q.size(), 0);
      miner_stall = 1'b0;

      // randomized sweeps
      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
         first = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 3) : $urandom;
         len = $urandom_range(0, 5);
         case ($urandom_range(0, 2))
            0:       tgt = 256'h0;
            1:       tgt = '1;
            default: tgt = {4'h0, {252{1'b1}}};
         endcase
         run_sweep("rand", hdr, first, first + len, tgt, 0, $urandom_range(0, 1) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
